// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the inter-stage pipeline registers of the
//   five-stage MIPS core.
//   - PIPE_NOP      : default bubble value (encodes sll $0,$0,0).
//   - pipe_occ_t    : 2-bit occupancy count type.
//   - *_bundle_t    : packed per-boundary bundles (F/D, D/E, E/M, M/W).
//   - FD_W..MW_W    : widths of those bundles, for DATA_W of each instance.
//   - occNext()     : occupancy update for one accept/drain cycle.
package pipe_pkg;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

  typedef logic [1:0] pipe_occ_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } fd_bundle_t;

  typedef struct packed {
    logic [31:0] pcPlus4;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic [31:0] immExt;
    logic [4:0]  rtIdx;
    logic [4:0]  rdIdx;
    logic [4:0]  shamt;
    logic [11:0] ctrl;
  } de_bundle_t;

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] rtVal;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  destReg;
    logic [5:0]  ctrl;
  } em_bundle_t;

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] memData;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  destReg;
    logic [2:0]  ctrl;
  } mw_bundle_t;

  localparam int FD_W = $bits(fd_bundle_t);
  localparam int DE_W = $bits(de_bundle_t);
  localparam int EM_W = $bits(em_bundle_t);
  localparam int MW_W = $bits(mw_bundle_t);

  // Accept and drain in the same cycle cancel out; the count never wraps
  // because the handshake keeps it inside the legal range.
  function automatic pipe_occ_t occNext(input pipe_occ_t occ,
                                        input logic accept,
                                        input logic drain);
    pipe_occ_t result;
    result = occ;
    if (accept && !drain) begin
      result = occ + 2'd1;
    end else if (drain && !accept) begin
      result = occ - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
//   One valid+data storage entry of a pipeline register. An empty slot
//   always holds BUBBLE_VAL so its data output is safe to forward as a nop.
//   Ports:
//     clk_i    rising-edge clock
//     rst_ni   asynchronous active-low reset (empties the slot)
//     load_i   capture data_i and mark valid
//     clear_i  empty the slot (wins over load_i)
//     data_i   incoming bundle
//     valid_o  slot holds a bundle
//     data_o   held bundle, BUBBLE_VAL when empty
module pipe_slot #(
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clear has priority so a flush can never leave a stale bundle behind.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = BUBBLE_VAL;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage register with valid/ready handshake and flush.
//   Configuration macro: PIPE_STAGE_REG_SKID_EN
//     defined   : main + skid entry, registered in_ready, occ 0..2
//     undefined : single entry, in_ready = !out_valid || out_ready, occ 0..1
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     in_valid   upstream offers in_data
//     in_ready   block accepts a bundle this cycle
//     in_data    upstream bundle
//     out_valid  out_data holds a valid bundle
//     out_ready  downstream takes out_data this cycle
//     out_data   bundle to downstream, BUBBLE_VAL when out_valid is low
//     flush      synchronous kill of held entries and this cycle's input
//     occ        number of entries held
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(PIPE_NOP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occ
);

  logic              inXfer;
  logic              outXfer;
  logic              mainValid;
  logic              mainLoad;
  logic              mainClear;
  logic [DATA_W-1:0] mainSrc;

  assign inXfer  = in_valid && in_ready;
  assign outXfer = mainValid && out_ready;

  pipe_slot #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) uMain (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (mainLoad),
    .clear_i (mainClear),
    .data_i  (mainSrc),
    .valid_o (mainValid),
    .data_o  (out_data)
  );

  assign out_valid = mainValid;

`ifdef PIPE_STAGE_REG_SKID_EN

  logic              skidValid;
  logic [DATA_W-1:0] skidData;
  logic              skidLoad;
  logic              skidClear;
  logic              inReady_q, inReady_d;
  pipe_occ_t         occ_q, occ_d;

  pipe_slot #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE_VAL)
  ) uSkid (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (skidLoad),
    .clear_i (skidClear),
    .data_i  (in_data),
    .valid_o (skidValid),
    .data_o  (skidData)
  );

  // Main refills whenever it is empty or draining: from skid first to keep
  // FIFO order, otherwise from the input. If main is held, a new bundle
  // parks in skid. Skid valid implies main valid, and in_ready is low while
  // skid is full, so accept-into-skid and skid-to-main never collide.
  always_comb begin
    mainLoad  = 1'b0;
    mainClear = 1'b0;
    mainSrc   = in_data;
    skidLoad  = 1'b0;
    skidClear = 1'b0;
    if (flush) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else if (outXfer || !mainValid) begin
      if (skidValid) begin
        mainLoad  = 1'b1;
        mainSrc   = skidData;
        skidClear = 1'b1;
      end else if (inXfer) begin
        mainLoad = 1'b1;
      end else begin
        mainClear = 1'b1;
      end
    end else if (inXfer) begin
      skidLoad = 1'b1;
    end
  end

  // in_ready mirrors the next skid state so it comes straight from a flop.
  always_comb begin
    inReady_d = !(skidLoad || (skidValid && !skidClear));
    occ_d     = flush ? 2'd0 : occNext(occ_q, inXfer, outXfer);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inReady_q <= 1'b1;
      occ_q     <= 2'd0;
    end else begin
      inReady_q <= inReady_d;
      occ_q     <= occ_d;
    end
  end

  assign in_ready = inReady_q;
  assign occ      = occ_q;

`else

  logic occ_q, occ_d;

  // With a single entry the block can take a new bundle only when the old
  // one is gone or leaving at this same edge.
  assign in_ready = !mainValid || out_ready;
  assign mainSrc  = in_data;

  always_comb begin
    mainLoad  = 1'b0;
    mainClear = 1'b0;
    occ_d     = occ_q;
    if (flush) begin
      mainClear = 1'b1;
      occ_d     = 1'b0;
    end else if (inXfer) begin
      mainLoad = 1'b1;
      occ_d    = 1'b1;
    end else if (outXfer) begin
      mainClear = 1'b1;
      occ_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = {1'b0, occ_q};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg with an 8-bit bundle and a zero bubble.
//   Covers both builds of PIPE_STAGE_REG_SKID_EN.
module tb_pipe_stage_reg;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] inData;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outData;
  logic              flush;
  logic [1:0]        occ;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sinkQ[$];

  pipe_stage_reg #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .flush     (flush),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  // Sink monitor: records every completed output transfer.
  always @(posedge clk) begin
    if (reset && outValid && outReady) begin
      sinkQ.push_back(outData);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                               input logic r, input logic f);
    inValid  = v;
    inData   = d;
    outReady = r;
    flush    = f;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic v,
                            input logic [DATA_W-1:0] d, input logic [1:0] o);
    checkOutput({tag, ".outValid"}, 32'(outValid), 32'(v));
    checkOutput({tag, ".outData"}, 32'(outData), 32'(d));
    checkOutput({tag, ".occ"}, 32'(occ), 32'(o));
  endtask

  task automatic checkSink(input string tag, input int n,
                           input logic [DATA_W-1:0] e0,
                           input logic [DATA_W-1:0] e1,
                           input logic [DATA_W-1:0] e2);
    logic [DATA_W-1:0] exp3 [3];
    exp3[0] = e0;
    exp3[1] = e1;
    exp3[2] = e2;
    checkOutput({tag, ".count"}, 32'(sinkQ.size()), 32'(n));
    for (int i = 0; i < n && i < sinkQ.size(); i++) begin
      checkOutput($sformatf("%s.item%0d", tag, i), 32'(sinkQ[i]), 32'(exp3[i]));
    end
    sinkQ.delete();
  endtask

  initial begin
    // reset is active-low in this design
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checkState("reset", 1'b0, 8'h00, 2'd0);
    checkOutput("reset.inReady", 32'(inReady), 32'd1);
    repeat (2) tick;
    reset = 1'b1;

    $display("[TB] streaming");
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    tick;
    checkState("stream11", 1'b1, 8'h11, 2'd1);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
    tick;
    checkState("stream22", 1'b1, 8'h22, 2'd1);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    tick;
    checkState("stream33", 1'b1, 8'h33, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick;
    checkState("streamEnd", 1'b0, 8'h00, 2'd0);
    checkSink("streamSink", 3, 8'h11, 8'h22, 8'h33);

`ifdef PIPE_STAGE_REG_SKID_EN
    $display("[TB] skid stall");
    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0);
    tick;
    checkState("stallA0", 1'b1, 8'hA0, 2'd1);
    checkOutput("stallA0.inReady", 32'(inReady), 32'd1);
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    tick;
    checkState("stallA1", 1'b1, 8'hA0, 2'd2);
    checkOutput("stallA1.inReady", 32'(inReady), 32'd0);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    tick;
    checkState("stallA2held", 1'b1, 8'hA0, 2'd2);
    checkOutput("stallA2held.inReady", 32'(inReady), 32'd0);
    applyStimulus(1'b1, 8'hA2, 1'b1, 1'b0);
    tick;
    checkState("release1", 1'b1, 8'hA1, 2'd1);
    checkOutput("release1.inReady", 32'(inReady), 32'd1);
    applyStimulus(1'b1, 8'hA2, 1'b1, 1'b0);
    tick;
    checkState("release2", 1'b1, 8'hA2, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick;
    checkState("release3", 1'b0, 8'h00, 2'd0);
    checkSink("stallSink", 3, 8'hA0, 8'hA1, 8'hA2);

    $display("[TB] flush with two entries held");
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    tick;
    checkState("flushFull", 1'b1, 8'hC0, 2'd2);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    tick;
    checkState("flushFullAfter", 1'b0, 8'h00, 2'd0);
    checkOutput("flushFullAfter.inReady", 32'(inReady), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick;
    tick;
    checkSink("flushFullSink", 0, 8'h00, 8'h00, 8'h00);
`else
    $display("[TB] single-entry ready path");
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    tick;
    checkState("single66", 1'b1, 8'h66, 2'd1);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    #1;
    checkOutput("singleStall.inReady", 32'(inReady), 32'd0);
    outReady = 1'b1;
    #1;
    checkOutput("singleGo.inReady", 32'(inReady), 32'd1);
    tick;
    checkState("single77", 1'b1, 8'h77, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick;
    checkState("singleEnd", 1'b0, 8'h00, 2'd0);
    checkSink("singleSink", 2, 8'h66, 8'h77, 8'h00);
`endif

    $display("[TB] flush with simultaneous accept");
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0);
    tick;
    checkState("flushB0", 1'b1, 8'hB0, 2'd1);
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1);
    #1;
    checkOutput("flushAccept.inReady", 32'(inReady), 32'd1);
    tick;
    checkState("flushAfter", 1'b0, 8'h00, 2'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick;
    tick;
    checkState("flushIdle", 1'b0, 8'h00, 2'd0);
    checkSink("flushSink", 1, 8'hB0, 8'h00, 8'h00);

    $display("[TB] drain during flush");
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    tick;
    checkState("drain05", 1'b1, 8'h05, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    tick;
    checkState("drainAfter", 1'b0, 8'h00, 2'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick;
    checkSink("drainSink", 1, 8'h05, 8'h00, 8'h00);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0);
    tick;
`ifdef PIPE_STAGE_REG_SKID_EN
    applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0);
    tick;
    checkState("preReset", 1'b1, 8'hD0, 2'd2);
`else
    checkState("preReset", 1'b1, 8'hD0, 2'd1);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkState("midReset", 1'b0, 8'h00, 2'd0);
    checkOutput("midReset.inReady", 32'(inReady), 32'd1);
    tick;
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick;
    checkState("postReset", 1'b0, 8'h00, 2'd0);
    checkSink("resetSink", 0, 8'h00, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
